// File: rtl/cpu_pkg.sv
// Shared CPU types and constants used by the divider writeback buffer.
package cpu_pkg;

  localparam int unsigned ROB_LEN      = 16;
  localparam int unsigned IDX_W        = $clog2(ROB_LEN);
  localparam int unsigned WB_DEPTH_DIV = 4;

  typedef struct packed {
    logic [IDX_W-1:0] rob_idx;
    logic [6:0]       rd;
    logic [31:0]      data;
  } wb_entry_t;

endpackage

// File: rtl/div_wb_buffer.sv
// Result FIFO between the pipelined divider and the CDB arbiter. It stalls the divider when
// full and drops mispredict-squashed results, both queued and arriving.
module div_wb_buffer
  import cpu_pkg::*;
#(
  parameter int unsigned Depth = WB_DEPTH_DIV
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mispredict,
  input  logic [ROB_LEN-1:0] flush_mask,
  input  logic               div_o_valid,
  input  logic [IDX_W-1:0]   div_o_rob_idx,
  input  logic [6:0]         div_o_rd,
  input  logic [31:0]        div_o_data,
  output logic               div_i_ready,
  output logic               cdb_valid,
  input  logic               cdb_ready,
  output logic [IDX_W-1:0]   cdb_rob_idx,
  output logic [6:0]         cdb_rd,
  output logic [31:0]        cdb_data
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam int unsigned PtrW  = AddrW + 1;

  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [Depth-1:0] v_q, v_d;
  wb_entry_t        mem_q [Depth];

  logic [AddrW-1:0] rd_addr, wr_addr;
  logic             full, empty;
  logic             push, pop;
  logic             head_v, head_squash, arrival_kill;
  logic [Depth-1:0] flush_hit;
  wb_entry_t        head;

  assign rd_addr = rd_ptr_q[AddrW-1:0];
  assign wr_addr = wr_ptr_q[AddrW-1:0];
  assign empty   = (rd_ptr_q == wr_ptr_q);
  assign full    = (rd_ptr_q[AddrW] != wr_ptr_q[AddrW]) && (rd_addr == wr_addr);

  // Per-entry squash compare against the entry's own ROB index.
  for (genvar i = 0; i < Depth; i++) begin : g_flush
    assign flush_hit[i] = mispredict & flush_mask[mem_q[i].rob_idx];
  end

  assign head         = mem_q[rd_addr];
  assign head_v       = v_q[rd_addr];
  assign head_squash  = flush_hit[rd_addr];
  assign arrival_kill = mispredict & flush_mask[div_o_rob_idx];

  assign div_i_ready = ~full;
  assign cdb_valid   = ~empty & head_v & ~head_squash;
  assign cdb_rob_idx = head.rob_idx;
  assign cdb_rd      = head.rd;
  assign cdb_data    = head.data;

  // A head being squashed this cycle leaves now rather than lingering one extra cycle.
  assign push = div_o_valid & ~full;
  assign pop  = ~empty & ((cdb_valid & cdb_ready) | ~head_v | head_squash);

  always_comb begin
    v_d      = v_q & ~flush_hit;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (pop) begin
      v_d[rd_addr] = 1'b0;
      rd_ptr_d     = rd_ptr_q + PtrW'(1);
    end
    if (push) begin
      v_d[wr_addr] = ~arrival_kill;
      wr_ptr_d     = wr_ptr_q + PtrW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      v_q      <= '0;
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      v_q      <= v_d;
      if (push) begin
        mem_q[wr_addr] <= '{rob_idx: div_o_rob_idx, rd: div_o_rd, data: div_o_data};
      end
    end
  end

endmodule

// File: tb/tb_div_wb_buffer.sv
// Randomised and directed bench for div_wb_buffer against a queue-based reference model.
module tb_div_wb_buffer;
  import cpu_pkg::*;

  localparam int Depth = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               mispredict;
  logic [ROB_LEN-1:0] flush_mask;
  logic               div_o_valid;
  logic [IDX_W-1:0]   div_o_rob_idx;
  logic [6:0]         div_o_rd;
  logic [31:0]        div_o_data;
  logic               div_i_ready;
  logic               cdb_valid;
  logic               cdb_ready;
  logic [IDX_W-1:0]   cdb_rob_idx;
  logic [6:0]         cdb_rd;
  logic [31:0]        cdb_data;

  div_wb_buffer #(.Depth(Depth)) dut (
    .clk           (clk),
    .rst           (rst),
    .mispredict    (mispredict),
    .flush_mask    (flush_mask),
    .div_o_valid   (div_o_valid),
    .div_o_rob_idx (div_o_rob_idx),
    .div_o_rd      (div_o_rd),
    .div_o_data    (div_o_data),
    .div_i_ready   (div_i_ready),
    .cdb_valid     (cdb_valid),
    .cdb_ready     (cdb_ready),
    .cdb_rob_idx   (cdb_rob_idx),
    .cdb_rd        (cdb_rd),
    .cdb_data      (cdb_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          live;
    int unsigned idx;
    int unsigned rd;
    int unsigned data;
  } mdl_t;

  mdl_t mdl_q[$];
  int   tests_run    = 0;
  int   tests_failed = 0;
  int   beats        = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One cycle: drive inputs, check outputs mid-cycle, then advance the model at the edge.
  task automatic step(input bit v, input int unsigned idx, input int unsigned rd,
                      input int unsigned data, input bit misp, input int unsigned mask,
                      input bit crdy);
    bit   exp_valid, squashed, do_pop, do_push;
    mdl_t h, n;
    div_o_valid   = v;
    div_o_rob_idx = IDX_W'(idx);
    div_o_rd      = 7'(rd);
    div_o_data    = data;
    mispredict    = misp;
    flush_mask    = ROB_LEN'(mask);
    cdb_ready     = crdy;
    @(negedge clk);
    exp_valid = 1'b0;
    squashed  = 1'b0;
    if (mdl_q.size() > 0) begin
      h         = mdl_q[0];
      squashed  = misp && mask[h.idx];
      exp_valid = h.live && !squashed;
      check_eq("cdb_rob_idx", 32'(cdb_rob_idx), h.idx);
      check_eq("cdb_rd", 32'(cdb_rd), h.rd);
      check_eq("cdb_data", cdb_data, h.data);
    end
    check_eq("cdb_valid", 32'(cdb_valid), 32'(exp_valid));
    check_eq("div_i_ready", 32'(div_i_ready), 32'(mdl_q.size() < Depth));
    if (cdb_valid && cdb_ready) beats++;
    do_push = v && (mdl_q.size() < Depth);
    do_pop  = (mdl_q.size() > 0) && ((exp_valid && crdy) || !h.live || squashed);
    @(posedge clk);
    if (misp) begin
      foreach (mdl_q[i]) if (mask[mdl_q[i].idx]) mdl_q[i].live = 1'b0;
    end
    if (do_pop) void'(mdl_q.pop_front());
    if (do_push) begin
      n.live = !(misp && mask[idx]);
      n.idx  = idx;
      n.rd   = rd;
      n.data = data;
      mdl_q.push_back(n);
    end
    #1;
  endtask

  task automatic idle(input bit crdy, input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 0, 0, 1'b0, 0, crdy);
  endtask

  task automatic do_reset();
    rst           = 1'b0;
    mispredict    = 1'b0;
    flush_mask    = '0;
    div_o_valid   = 1'b0;
    div_o_rob_idx = '0;
    div_o_rd      = '0;
    div_o_data    = '0;
    cdb_ready     = 1'b0;
    repeat (2) @(posedge clk);
    mdl_q.delete();
    #1;
    rst = 1'b1;
  endtask

  initial begin
    int b0;
    int unsigned bits;
    // T1 reset
    do_reset();
    @(negedge clk);
    check_eq("rst_cdb_valid", 32'(cdb_valid), 0);
    check_eq("rst_ready", 32'(div_i_ready), 1);
    check_eq("rst_cdb_data", cdb_data, 0);
    @(posedge clk);
    #1;

    // T2 basic single result
    b0 = beats;
    step(1'b1, 3, 5, 32'h7, 1'b0, 0, 1'b1);
    idle(1'b1, 2);
    check_eq("t2_beats", 32'(beats - b0), 1);

    // T3 backpressure to full, then drain in order
    b0 = beats;
    for (int i = 1; i <= 4; i++) step(1'b1, i, 10 + i, i, 1'b0, 0, 1'b0);
    idle(1'b0, 1);
    idle(1'b1, 6);
    check_eq("t3_beats", 32'(beats - b0), 4);

    // T4 flush of queued entries
    b0 = beats;
    step(1'b1, 2, 20, 32'h22, 1'b0, 0, 1'b0);
    step(1'b1, 5, 21, 32'h55, 1'b0, 0, 1'b0);
    step(1'b1, 6, 22, 32'h66, 1'b0, 0, 1'b0);
    step(1'b0, 0, 0, 0, 1'b1, 32'h60, 1'b0);
    idle(1'b1, 4);
    check_eq("t4_beats", 32'(beats - b0), 1);

    // T5 squash on arrival
    b0 = beats;
    step(1'b1, 7, 30, 32'h77, 1'b1, 32'h80, 1'b1);
    idle(1'b1, 3);
    check_eq("t5_beats", 32'(beats - b0), 0);

    // All-zero mask mispredict is a no-op
    b0 = beats;
    step(1'b1, 9, 40, 32'h99, 1'b0, 0, 1'b0);
    step(1'b0, 0, 0, 0, 1'b1, 0, 1'b0);
    idle(1'b1, 2);
    check_eq("zero_mask_beats", 32'(beats - b0), 1);

    // Reset mid-operation
    for (int i = 0; i < 3; i++) step(1'b1, i, i, 32'hA0 + i, 1'b0, 0, 1'b0);
    do_reset();
    @(negedge clk);
    check_eq("midrst_valid", 32'(cdb_valid), 0);
    check_eq("midrst_ready", 32'(div_i_ready), 1);
    @(posedge clk);
    #1;

    // T6 random push/pop with toggling cdb_ready and occasional flushes
    for (int c = 0; c < 300; c++) begin
      bits = $urandom;
      step((bits[1:0] != 2'b00) && (mdl_q.size() < Depth), $urandom_range(0, ROB_LEN - 1),
           $urandom_range(0, 127), $urandom, (bits[6:3] == 4'h0), $urandom, c[0]);
    end
    idle(1'b1, 8);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
